// File: rtl/matrix_wb_arbiter.sv
// rtl/matrix_wb_arbiter.sv - round-robin two-master pipelined Wishbone arbiter for the matrix slave
// Whole bus cycles are granted; outstanding strobes are capped and a hung cycle is aborted with err.
module matrix_wb_arbiter #(
  parameter int AW      = 3,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [SW-1:0] i_m0_sel,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_ack,
  output logic          o_m0_stall,
  output logic          o_m0_err,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [SW-1:0] i_m1_sel,
  input  logic [DW-1:0] i_m1_wdata,
  output logic          o_m1_ack,
  output logic          o_m1_stall,
  output logic          o_m1_err,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [SW-1:0] o_wb_sel,
  output logic [DW-1:0] o_wb_wdata,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic [DW-1:0] i_wb_rdata,
  output logic [1:0]    o_grant
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [OW-1:0] OUT_FULL = OW'(MAX_OUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, ABORT0, ABORT1} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic own0, own1, granted, sel1, cyc_own, cyc_other, stb_own, full, accept, tmo_hit;

  assign own0      = (state_q == GRANT0);
  assign own1      = (state_q == GRANT1);
  assign granted   = own0 | own1;
  assign sel1      = (state_q == GRANT1) || (state_q == ABORT1);
  assign cyc_own   = sel1 ? i_m1_cyc : i_m0_cyc;
  assign cyc_other = sel1 ? i_m0_cyc : i_m1_cyc;
  assign stb_own   = sel1 ? i_m1_stb : i_m0_stb;
  assign full      = (outst_q == OUT_FULL);

  assign o_wb_cyc   = granted & cyc_own;
  assign o_wb_stb   = granted & cyc_own & stb_own & ~full;
  assign o_wb_we    = granted & (sel1 ? i_m1_we : i_m0_we);
  assign o_wb_addr  = granted ? (sel1 ? i_m1_addr : i_m0_addr) : '0;
  assign o_wb_sel   = granted ? (sel1 ? i_m1_sel : i_m0_sel) : '0;
  assign o_wb_wdata = granted ? (sel1 ? i_m1_wdata : i_m0_wdata) : '0;

  assign accept  = o_wb_stb & ~i_wb_stall;
  // Abort fires on the last tolerated cycle so err is seen before cyc is dropped.
  assign tmo_hit = granted & cyc_own & (outst_q != '0) & ~i_wb_ack & (tmo_q == TMO_LAST);

  assign o_m0_ack   = own0 & i_wb_ack;
  assign o_m1_ack   = own1 & i_wb_ack;
  assign o_m0_err   = own0 & tmo_hit;
  assign o_m1_err   = own1 & tmo_hit;
  assign o_m0_stall = ~own0 | i_wb_stall | full;
  assign o_m1_stall = ~own1 | i_wb_stall | full;
  assign o_m0_rdata = i_wb_rdata;
  assign o_m1_rdata = i_wb_rdata;
  assign o_grant    = {(state_q == GRANT1) || (state_q == ABORT1),
                       (state_q == GRANT0) || (state_q == ABORT0)};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    outst_d = outst_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last_q)) state_d = GRANT0;
        else if (i_m1_cyc)                     state_d = GRANT1;
      end
      GRANT0, GRANT1, ABORT0, ABORT1: begin
        if (!cyc_own) begin
          state_d = cyc_other ? (sel1 ? GRANT0 : GRANT1) : IDLE;
          last_d  = sel1;
          outst_d = '0;
          tmo_d   = '0;
        end else if (granted && tmo_hit) begin
          state_d = sel1 ? ABORT1 : ABORT0;
          outst_d = '0;
          tmo_d   = '0;
        end else if (granted) begin
          if (accept && !i_wb_ack)                      outst_d = outst_q + OW'(1);
          else if (!accept && i_wb_ack && outst_q != '0) outst_d = outst_q - OW'(1);
          if (i_wb_ack || outst_q == '0) tmo_d = '0;
          else                           tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      outst_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_matrix_wb_arbiter.sv
// tb/tb_matrix_wb_arbiter.sv - self-checking bench for matrix_wb_arbiter
module tb_matrix_wb_arbiter;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_m0_cyc, i_m0_stb, i_m0_we;
  logic [AW-1:0] i_m0_addr;
  logic [SW-1:0] i_m0_sel;
  logic [DW-1:0] i_m0_wdata;
  logic          o_m0_ack, o_m0_stall, o_m0_err;
  logic [DW-1:0] o_m0_rdata;
  logic          i_m1_cyc, i_m1_stb, i_m1_we;
  logic [AW-1:0] i_m1_addr;
  logic [SW-1:0] i_m1_sel;
  logic [DW-1:0] i_m1_wdata;
  logic          o_m1_ack, o_m1_stall, o_m1_err;
  logic [DW-1:0] o_m1_rdata;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [SW-1:0] o_wb_sel;
  logic [DW-1:0] o_wb_wdata;
  logic          i_wb_ack, i_wb_stall;
  logic [DW-1:0] i_wb_rdata;
  logic [1:0]    o_grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_wb_arbiter #(.AW(AW), .DW(DW), .SW(SW), .MAX_OUT(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
    .i_m0_sel(i_m0_sel), .i_m0_wdata(i_m0_wdata), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall),
    .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
    .i_m1_sel(i_m1_sel), .i_m1_wdata(i_m1_wdata), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall),
    .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .i_wb_rdata(i_wb_rdata), .o_grant(o_grant)
  );

  // in = {m0_cyc, m0_stb, m1_cyc, m1_stb, wb_ack, wb_stall}
  // exp = {grant[1:0], wb_cyc, wb_stb, m0_ack, m0_stall, m0_err, m1_ack, m1_stall, m1_err}
  typedef struct {
    logic [5:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [DW+AW+SW:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] in);
    {i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb, i_wb_ack, i_wb_stall} = in;
  endtask

  function automatic logic [9:0] observe();
    return {o_grant, o_wb_cyc, o_wb_stb, o_m0_ack, o_m0_stall, o_m0_err,
            o_m1_ack, o_m1_stall, o_m1_err};
  endfunction

  task automatic add(input logic [5:0] in, input logic [9:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    drive(6'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [DW+AW+SW:0] got;
    logic [DW+AW+SW:0] want;
    int acks;

    i_m0_we = 1'b1; i_m0_addr = '0; i_m0_sel = 4'hF; i_m0_wdata = '0;
    i_m1_we = 1'b0; i_m1_addr = 3'd7; i_m1_sel = 4'h3; i_m1_wdata = 32'hDEAD_BEEF;
    i_wb_rdata = 32'hCAFE_F00D;
    reset = 1'b0;
    drive(6'b0);
    #3;
    check("reset_outputs", {54'd0, observe()}, {54'd0, 10'b0000_010_010});
    check("reset_wb_bus", {{(64-1-AW-SW-DW){1'b0}}, o_wb_we, o_wb_addr, o_wb_sel, o_wb_wdata}, 64'd0);
    do_reset();

    // Single master: 8 pipelined writes, slave acks one cycle after acceptance
    acks = 0;
    for (int c = 0; c <= 10; c++) begin
      tick();
      i_m0_cyc   = (c <= 9);
      i_m0_stb   = (c <= 8);
      i_m0_addr  = (c >= 1) ? AW'(c - 1) : '0;
      i_m0_wdata = 32'h0101_0101 * DW'(i_m0_addr);
      i_wb_ack   = (c >= 2 && c <= 9);
      i_wb_stall = 1'b0;
      if (c >= 1 && c <= 8) sb_q.push_back({1'b1, i_m0_addr, 4'hF, i_m0_wdata});
      #3;
      check("single_cycle", {59'd0, o_grant, o_wb_cyc, o_wb_stb, o_m0_ack, o_m1_stall},
            {59'd0, (c >= 1) ? 2'b01 : 2'b00, (c >= 1 && c <= 9), (c >= 1 && c <= 8),
             (c >= 2 && c <= 9), 1'b1});
      if (o_m0_ack) acks++;
      if (o_wb_stb && !i_wb_stall) begin
        got = {o_wb_we, o_wb_addr, o_wb_sel, o_wb_wdata};
        if (sb_q.size() == 0) begin
          check("single_unexpected_strobe", 64'(got), 64'd0);
        end else begin
          want = sb_q.pop_front();
          check("single_write", 64'(got), 64'(want));
        end
      end
    end
    check("single_ack_count", 64'(acks), 64'd8);
    check("single_sb_empty", 64'(sb_q.size()), 64'd0);
    check("single_rdata", {o_m0_rdata, o_m1_rdata}, {2{32'hCAFE_F00D}});

    // Tie, round-robin, outstanding cap, late ack
    add(6'b10_10_00, 10'b0000_010_010);
    add(6'b11_10_00, 10'b0111_000_010);
    add(6'b10_10_10, 10'b0110_100_010);
    add(6'b00_10_00, 10'b0100_000_010);
    add(6'b00_11_00, 10'b1011_010_000);
    add(6'b00_10_10, 10'b1010_010_100);
    add(6'b00_00_00, 10'b1000_010_000);
    add(6'b10_10_00, 10'b0000_010_010);
    add(6'b10_10_00, 10'b0110_000_010);
    for (int i = 0; i < 4; i++) add(6'b11_10_00, 10'b0111_000_010);
    add(6'b11_10_00, 10'b0110_010_010);
    add(6'b11_10_10, 10'b0110_110_010);
    add(6'b11_10_00, 10'b0111_000_010);
    add(6'b11_10_00, 10'b0110_010_010);
    add(6'b10_10_10, 10'b0110_110_010);
    for (int i = 0; i < 3; i++) add(6'b10_10_10, 10'b0110_100_010);
    add(6'b11_00_00, 10'b0111_000_010);
    add(6'b00_00_00, 10'b0100_000_010);
    add(6'b00_10_10, 10'b0000_010_010);
    add(6'b00_10_00, 10'b1010_010_000);
    add(6'b00_00_00, 10'b1000_010_000);
    add(6'b00_00_00, 10'b0000_010_010);

    i_m0_addr = 3'd2; i_m0_wdata = 32'h1234_5678;
    do_reset();
    foreach (tbl[i]) begin
      tick();
      drive(tbl[i].in);
      #3;
      check($sformatf("table_row%0d", i), {54'd0, observe()}, {54'd0, tbl[i].exp});
    end

    // Timeout: one accepted strobe never acked, m1 waiting
    for (int t = 0; t <= 21; t++) begin
      tick();
      if (t <= 1)       drive(6'b11_10_00);
      else if (t <= 19) drive(6'b10_10_00);
      else if (t == 20) drive(6'b00_10_00);
      else              drive(6'b00_11_00);
      #3;
      check($sformatf("timeout_t%0d", t), {60'd0, o_grant, o_wb_cyc, o_m0_err},
            {60'd0, (t == 0) ? 2'b00 : (t == 21) ? 2'b10 : 2'b01,
             (t >= 1 && t <= 17) || t == 21, t == 17});
      if (t >= 18 && t <= 20) check("abort_stall", {63'd0, o_m0_stall}, 64'd1);
    end

    // Reset asserted mid-burst with two strobes outstanding on m1
    tick();
    drive(6'b00_11_00);
    tick();
    drive(6'b00_10_00);
    #1;
    check("pre_reset_grant", {61'd0, o_grant, o_wb_cyc}, {61'd0, 2'b10, 1'b1});
    reset = 1'b0;
    #1;
    check("midreset_outputs", {54'd0, observe()}, {54'd0, 10'b0000_010_010});
    drive(6'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drive(6'b10_10_00);
    tick();
    #3;
    check("post_reset_tie", {62'd0, o_grant}, {62'd0, 2'b01});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_wb_arbiter.md
# matrix_wb_arbiter

Two-master Wishbone (pipelined) arbiter that shares the single `matrix` framebuffer slave (32-bit data, 3-bit word address, 4-bit byte select) between the `move_master` pattern sequencer (port 0) and a second command master such as a UART/ESP32 bridge (port 1). It sits in `top` between the masters and `matrix`. It grants whole bus cycles round-robin, caps outstanding requests, and aborts a hung cycle with a bus error after a timeout.

## Interface
- `AW`, 3, address width (matches `matrix` word address).
- `DW`, 32, data width; `SW` = DW/8 byte selects.
- `MAX_OUT`, 4, max accepted-but-unacknowledged strobes per cycle (≥1).
- `TIMEOUT`, 255, cycles with outstanding>0 and no ack before abort (≥1).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `i_m0_cyc`, `i_m0_stb`, `i_m0_we`  in  1 each  master 0 request.
- `i_m0_addr`  in  AW; `i_m0_sel`  in  SW; `i_m0_wdata`  in  DW.
- `o_m0_ack`, `o_m0_stall`, `o_m0_err`  out  1 each; `o_m0_rdata`  out  DW.
- `i_m1_*` / `o_m1_*`  identical set for master 1.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each; `o_wb_addr` out AW; `o_wb_sel` out SW; `o_wb_wdata` out DW  to slave.
- `i_wb_ack`, `i_wb_stall`  in  1 each; `i_wb_rdata`  in  DW  from slave.
- `o_grant`  out  2  one-hot current owner (00 = none).

## Operation
- States: IDLE, GRANT0, GRANT1, ABORT0, ABORT1. Registered: state, `last` (last granted port), `outst` (0..MAX_OUT), `tmo` counter.
- IDLE: `o_wb_cyc`=`o_wb_stb`=0; both `o_mN_stall`=1, ack/err=0. If exactly one `i_mN_cyc` high → GRANTN. Both high → port ≠ `last`. `last` resets to 1, so port 0 wins the first tie.
- GRANTN: `o_wb_cyc`=`i_mN_cyc`; `o_wb_we/addr/sel/wdata` = master N fields (combinational mux). `o_wb_stb`=`i_mN_stb` & (outst<MAX_OUT). `o_mN_stall`=`i_wb_stall` | (outst==MAX_OUT). `o_mN_ack`=`i_wb_ack`. Non-owner: stall=1, ack=0, err=0.
- `o_m0_rdata`=`o_m1_rdata`=`i_wb_rdata` (broadcast; qualified by ack).
- outst: +1 on `o_wb_stb`&~`i_wb_stall`, −1 on `i_wb_ack`. Both in the same cycle → unchanged. Ack with outst==0 is still forwarded; outst saturates at 0.
- Release: when `i_mN_cyc` falls in GRANTN → next state GRANT(other) if other's cyc high, else IDLE. `last`←N; outst, tmo ←0. Late acks after release are not forwarded.
- Timeout: tmo increments each GRANTN cycle with outst>0 and no ack. It clears on ack or when outst==0. On the cycle tmo==TIMEOUT−1 and still no ack: `o_mN_err`=1 for that one cycle, then → ABORTN.
- ABORTN: `o_wb_cyc`=0, `o_mN_stall`=1, ack=0. Stay until `i_mN_cyc`=0, then release exactly as above.
- `o_grant`: bit N high in GRANTN/ABORTN.

## Timing
- Reset (async assert, sync deassert by consumer): state=IDLE, last=1, outst=0, tmo=0. All `o_wb_*`=0, `o_grant`=00, all `o_mN_ack`/`o_mN_err`=0, all `o_mN_stall`=1.
- Grant latency: cyc high at cycle t in IDLE → `o_grant` and `o_wb_cyc` at t+1. The first strobe can be accepted at t+1.
- Request→slave path and ack/stall→master path are combinational (0 cycles added).
- Handover without IDLE: owner drops cyc at t, other requesting → other granted at t+1. Slave sees `o_wb_cyc`=0 for cycle t, giving ≥1 idle cycle between owners.
- Abort: error visible in the TIMEOUT-th stalled cycle; `o_wb_cyc` low from the next cycle.
- Reset asserted mid-cycle: all outputs return to reset values immediately (async).

## Test plan
- Single master: m0 writes 8 words (addr 0..7, sel 4'hF, data 32'h0101_0101×addr) pipelined, slave acks 1 cycle later → 8 acks on m0, `o_grant`=01 from cycle 1, m1 stall=1 throughout.
- Tie: m0 and m1 raise cyc in the same cycle after reset → m0 granted. m0 drops cyc after 1 write → m1 granted the next cycle. Both then re-request → m0 granted (round-robin).
- Outstanding cap: MAX_OUT=4, slave withholds ack, m0 strobes continuously → exactly 4 strobes reach the slave. `o_m0_stall`=1 after the 4th; one ack releases exactly one more strobe.
- Timeout: TIMEOUT=16, slave never acks one accepted strobe → `o_m0_err` pulses for 1 cycle 16 cycles after acceptance, then `o_wb_cyc`=0. m0 drops cyc → IDLE, m1 pending is then granted.
- Late ack: m0 drops cyc with outst=1, slave acks next cycle → no ack on m0 or m1; m1 grant unaffected.
- Reset mid-burst: `reset` low while GRANT1 with outst=2 → `o_wb_cyc`=0 and `o_grant`=00 in the same cycle. After release, the first tie goes to m0.
